// File: rtl/nios_cpu_pllcfg_status_in.sv
// Avalon-MM status input port for the PLL reconfiguration return path:
// synchronised inputs, sticky edge capture, masked level interrupt.
module nios_cpu_pllcfg_status_in #(
    parameter int               WIDTH          = 10,
    parameter int               SYNC_STAGES    = 2,
    parameter int               EDGE_TYPE      = 0,
    parameter int               BIT_CLEARING   = 1,
    parameter logic [WIDTH-1:0] IRQ_MASK_RESET = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int PRIME_MAX = SYNC_STAGES + 1;
    localparam int PRIME_W   = $clog2(PRIME_MAX + 1);

    logic [WIDTH-1:0]   sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]   in_sync;
    logic [WIDTH-1:0]   in_d1;
    logic [WIDTH-1:0]   edge_hit;
    logic [WIDTH-1:0]   clr_bits;
    logic [WIDTH-1:0]   edgecapture;
    logic [WIDTH-1:0]   irqmask;
    logic [PRIME_W-1:0] prime_cnt;
    logic               primed;
    logic               wr_en;
    logic [31:0]        rd_mux;

    assign in_sync = sync_q[SYNC_STAGES-1];
    assign primed  = (prime_cnt == PRIME_W'(PRIME_MAX));
    assign wr_en   = chipselect & ~write_n;

    // NOTE: this array is a short flop chain, not a RAM, so it is reset like
    // any other register; a true memory array would be left unreset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            in_d1 <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage sample the old
            // value of its predecessor, which is what makes this a shift chain.
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            in_d1 <= in_sync;
        end
    end

    // Edge detection stays suppressed until the chain has flushed its reset zeros.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            prime_cnt <= '0;
        else if (!primed)
            prime_cnt <= prime_cnt + 1'b1;
    end

    // NOTE: defaults first on every combinational output, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        edge_hit = '0;
        if (primed) begin
            case (EDGE_TYPE)
                0:       edge_hit = in_sync & ~in_d1;
                1:       edge_hit = ~in_sync & in_d1;
                default: edge_hit = in_sync ^ in_d1;
            endcase
        end
    end

    always_comb begin
        clr_bits = '0;
        if (wr_en && address == 2'd3)
            clr_bits = (BIT_CLEARING != 0) ? writedata[WIDTH-1:0] : '1;
    end

    // Set is OR-ed in after the clear, so a same-cycle edge survives a clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edgecapture <= '0;
            irqmask     <= IRQ_MASK_RESET;
        end else begin
            edgecapture <= (edgecapture & ~clr_bits) | edge_hit;
            if (wr_en && address == 2'd2)
                irqmask <= writedata[WIDTH-1:0];
        end
    end

    assign irq = |(edgecapture & irqmask);

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux[WIDTH-1:0] = in_sync;
            2'd2:    rd_mux[WIDTH-1:0] = irqmask;
            2'd3:    rd_mux[WIDTH-1:0] = edgecapture;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            readdata <= '0;
        else if (chipselect)
            readdata <= rd_mux;
    end

    if (WIDTH < 32) begin : g_unused
        logic unused_writedata;
        assign unused_writedata = ^writedata[31:WIDTH];
    end

endmodule

// File: tb/tb_nios_cpu_pllcfg_status_in.sv
// Directed plus randomized bench for the PLLCFG status input port; two
// instances cover rising/bit-clear and any-edge/clear-all configurations.
module tb_nios_cpu_pllcfg_status_in;

    localparam int W = 10;
    localparam int S = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [W-1:0]  in_port;
    logic [31:0]   rd_a, rd_b;
    logic          irq_a, irq_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nios_cpu_pllcfg_status_in #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(0), .BIT_CLEARING(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_a), .in_port(in_port), .irq(irq_a)
    );

    nios_cpu_pllcfg_status_in #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(2), .BIT_CLEARING(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_b), .in_port(in_port), .irq(irq_b)
    );

    // Reference model: hist[k-1] is in_port as sampled at the k-th clock after
    // reset release; a change sampled at clock k is visible as synchronised
    // data after clock k+S-1 and is captured at clock k+S, from clock S+2 on.
    logic [W-1:0] hist[$];
    int           n;
    logic [W-1:0] m_ec_a, m_ec_b, m_mask;
    logic [31:0]  m_rd_a, m_rd_b;
    logic [W-1:0] cur, prev, ev_a, ev_b, clr_a, clr_b;

    function automatic logic [W-1:0] samp(input int k);
        if (k < 1 || k > hist.size()) return '0;
        return hist[k-1];
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist.delete();
            n      = 0;
            m_ec_a = '0;
            m_ec_b = '0;
            m_mask = '0;
            m_rd_a = '0;
            m_rd_b = '0;
        end else begin
            n = n + 1;
            hist.push_back(in_port);
            cur  = samp(n - S);
            prev = samp(n - S - 1);
            ev_a = (n >= S + 2) ? (cur & ~prev) : '0;
            ev_b = (n >= S + 2) ? (cur ^ prev)  : '0;
            if (chipselect) begin
                case (address)
                    2'd0: begin m_rd_a = 32'(cur);    m_rd_b = 32'(cur);    end
                    2'd2: begin m_rd_a = 32'(m_mask); m_rd_b = 32'(m_mask); end
                    2'd3: begin m_rd_a = 32'(m_ec_a); m_rd_b = 32'(m_ec_b); end
                    default: begin m_rd_a = '0; m_rd_b = '0; end
                endcase
            end
            clr_a = '0;
            clr_b = '0;
            if (chipselect && !write_n) begin
                if (address == 2'd3) begin
                    clr_a = writedata[W-1:0];
                    clr_b = '1;
                end
                if (address == 2'd2) m_mask = writedata[W-1:0];
            end
            m_ec_a = (m_ec_a & ~clr_a) | ev_a;
            m_ec_b = (m_ec_b & ~clr_b) | ev_b;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_rd(input logic [1:0] a);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        @(negedge clk);
        chipselect = 1'b0;
    endtask

    initial begin
        chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
        in_port = '1; reset_n = 1'b0;

        // Reset with inputs already high: no spurious capture after release.
        idle(3);
        check("rst_rd_hold", rd_a, 32'h0);
        check("rst_irq_hold", 32'(irq_a), 32'h0);
        reset_n = 1'b1;
        idle(10);
        check("rst_irq_a", 32'(irq_a), 32'h0);
        check("rst_irq_b", 32'(irq_b), 32'h0);
        bus_rd(2'd3);
        check("rst_ec_a", rd_a, 32'h0);
        check("rst_ec_b", rd_b, 32'h0);
        bus_rd(2'd0);
        check("rst_data", rd_a, 32'h3FF);
        bus_rd(2'd2);
        check("rst_mask", rd_a, 32'h0);

        // Capture latency: change sampled at E0 -> captured at E2.
        bus_wr(2'd2, 32'h001);
        in_port[0] = 1'b0;
        idle(5);
        in_port[0] = 1'b1;
        @(negedge clk);
        check("lat_e0_irq", 32'(irq_a), 32'h0);
        @(negedge clk);
        check("lat_e1_irq", 32'(irq_a), 32'h0);
        @(negedge clk);
        check("lat_e2_irq", 32'(irq_a), 32'h1);
        bus_rd(2'd3);
        check("lat_ec", rd_a, 32'h001);

        // Masked capture, mask enable, per-bit clear; upper writedata ignored.
        bus_wr(2'd3, 32'h001);
        bus_wr(2'd2, 32'h000);
        check("mask0_irq", 32'(irq_a), 32'h0);
        in_port[5] = 1'b0;
        idle(5);
        in_port[5] = 1'b1;
        idle(5);
        bus_rd(2'd3);
        check("b5_ec", rd_a, 32'h020);
        check("b5_irq_masked", 32'(irq_a), 32'h0);
        bus_wr(2'd2, 32'hFFFF_FC20);
        check("b5_irq_unmasked", 32'(irq_a), 32'h1);
        bus_rd(2'd2);
        check("mask_width", rd_a, 32'h020);
        bus_wr(2'd3, 32'h020);
        check("b5_irq_cleared", 32'(irq_a), 32'h0);
        bus_rd(2'd3);
        check("b5_ec_cleared", rd_a, 32'h0);

        // Clear and capture on the same bit in the same cycle: set wins.
        in_port[0] = 1'b0;
        idle(5);
        in_port[0] = 1'b1;
        idle(2);
        bus_wr(2'd3, 32'h001);
        bus_rd(2'd3);
        check("set_wins", rd_a, 32'h001);

        // Any-edge / clear-all instance.
        bus_wr(2'd3, 32'h0);
        bus_rd(2'd3);
        check("anyclr_b", rd_b, 32'h0);
        check("anyclr_a_kept", rd_a, 32'h001);
        in_port[1] = ~in_port[1];
        in_port[9] = ~in_port[9];
        idle(5);
        bus_rd(2'd3);
        check("any_ec_b", rd_b, 32'h202);
        check("fall_ignored_a", rd_a, 32'h001);
        bus_wr(2'd3, 32'h0);
        bus_rd(2'd3);
        check("any_clr_b", rd_b, 32'h0);
        check("w1c_zero_a", rd_a, 32'h001);

        // Mid-operation reset is asynchronous and re-arms the priming window.
        in_port = '0;
        idle(5);
        in_port = '1;
        idle(5);
        bus_wr(2'd2, 32'h3FF);
        bus_rd(2'd3);
        check("full_ec_a", rd_a, 32'h3FF);
        check("full_irq_a", 32'(irq_a), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_irq_a", 32'(irq_a), 32'h0);
        check("async_irq_b", 32'(irq_b), 32'h0);
        check("async_rd_a", rd_a, 32'h0);
        in_port = W'($urandom);
        @(negedge clk);
        reset_n = 1'b1;
        in_port = 10'h155;
        idle(S + 2);
        bus_rd(2'd3);
        check("prime_ec_a", rd_a, 32'h0);
        check("prime_ec_b", rd_b, 32'h0);
        check("prime_irq", 32'(irq_a), 32'h0);
        bus_rd(2'd2);
        check("prime_mask", rd_a, 32'h0);
        bus_rd(2'd0);
        check("prime_data", rd_a, 32'h155);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                reset_n = 1'b0;
                #1;
                reset_n = 1'b1;
            end
            chipselect = 1'($urandom_range(0, 1));
            write_n    = ($urandom_range(0, 3) != 0);
            address    = 2'($urandom_range(0, 3));
            writedata  = $urandom;
            if ($urandom_range(0, 2) == 0) in_port = W'($urandom);
            @(negedge clk);
            check("rnd_rd_a", rd_a, m_rd_a);
            check("rnd_rd_b", rd_b, m_rd_b);
            check("rnd_irq_a", 32'(irq_a), 32'(|(m_ec_a & m_mask)));
            check("rnd_irq_b", 32'(irq_b), 32'(|(m_ec_b & m_mask)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
